// File: rtl/ltl_symbol_encoder.sv
// ltl_symbol_encoder: packs trace propositions into monitor symbols.
// Optional stutter removal via `define LTL_ENC_DEDUP_EN.
module ltl_symbol_encoder #(
  parameter int          PROP_W       = 7,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          RESET_CYCLES = 2,
  parameter logic [7:0]  EOT_SYMBOL   = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_start,
  input  logic              trace_end,
  input  logic              ev_valid,
  input  logic [PROP_W-1:0] ev_props,
  output logic              ev_ready,
  output logic              mon_reset,
  output logic              mon_run,
  output logic [7:0]        mon_symbols,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RST,
    STREAM,
    EOT
  } state_t;

  state_t            state;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [PROP_W-1:0] mem [FIFO_DEPTH];
  logic              end_pending;
  logic [CW-1:0]     rst_cnt;

  logic full;
  logic empty;
  logic active;
  logic accept;
  logic push;
  logic pop;
  logic bypass;
  logic wr_en;
  logic rst_last;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign active   = (state == RST) || (state == STREAM);
  assign ev_ready = active && !full && !end_pending;
  assign accept   = ev_valid && ev_ready && !trace_start;

`ifdef LTL_ENC_DEDUP_EN
  logic              have_last;
  logic [PROP_W-1:0] last_props;

  assign push = accept && !(have_last && (ev_props == last_props));
`else
  assign push = accept;
`endif

  // an event arriving into an empty FIFO while streaming skips storage
  assign pop      = (state == STREAM) && !empty;
  assign bypass   = (state == STREAM) && empty && push;
  assign wr_en    = push && !bypass;
  assign rst_last = (rst_cnt == CW'(RESET_CYCLES - 1));

  // event storage; contents only read while non-empty
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= ev_props;
  end

`ifdef LTL_ENC_DEDUP_EN
  // last pushed props, forgotten at every trace start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_last  <= 1'b0;
      last_props <= '0;
    end else if (trace_start) begin
      have_last  <= 1'b0;
      last_props <= '0;
    end else if (push) begin
      have_last  <= 1'b1;
      last_props <= ev_props;
    end
  end
`endif

  // framing FSM, FIFO pointers, drop counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      end_pending <= 1'b0;
      rst_cnt     <= '0;
      drop_cnt    <= '0;
      mon_reset   <= 1'b0;
      mon_run     <= 1'b0;
      mon_symbols <= '0;
      busy        <= 1'b0;
    end else begin
      mon_run     <= 1'b0;
      mon_symbols <= '0;
      if (wr_en)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (active && ev_valid && !ev_ready && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (trace_start) begin
        state       <= RST;
        rst_cnt     <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        end_pending <= 1'b0;
        drop_cnt    <= '0;
        mon_reset   <= 1'b1;
        busy        <= 1'b1;
      end else begin
        if (trace_end && active)
          end_pending <= 1'b1;
        unique case (state)
          IDLE: ;
          RST: begin
            if (rst_last) begin
              state     <= STREAM;
              mon_reset <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + CW'(1);
            end
          end
          STREAM: begin
            if (pop) begin
              mon_run     <= 1'b1;
              mon_symbols <= 8'(mem[rd_ptr[AW-1:0]]);
            end else if (end_pending) begin
              state       <= EOT;
              mon_run     <= 1'b1;
              mon_symbols <= EOT_SYMBOL;
            end else if (bypass) begin
              mon_run     <= 1'b1;
              mon_symbols <= 8'(ev_props);
            end
          end
          EOT: begin
            state       <= IDLE;
            busy        <= 1'b0;
            end_pending <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltl_symbol_encoder.sv
// tb_ltl_symbol_encoder: directed scoreboard bench for ltl_symbol_encoder.
// u_dut uses the default reset length, u_long a long one to let the FIFO fill.
module tb_ltl_symbol_encoder;

  logic       clk;
  logic       rst_n;
  logic       trace_start;
  logic       trace_end;
  logic       ev_valid;
  logic [6:0] ev_props;

  logic        m_ev_ready, m_mon_reset, m_mon_run, m_busy;
  logic [7:0]  m_mon_symbols;
  logic [15:0] m_drop_cnt;
  logic        l_ev_ready, l_mon_reset, l_mon_run, l_busy;
  logic [7:0]  l_mon_symbols;
  logic [15:0] l_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit en_m = 0;
  bit en_l = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  ltl_symbol_encoder u_dut (
    .clk(clk), .rst_n(rst_n),
    .trace_start(trace_start), .trace_end(trace_end),
    .ev_valid(ev_valid), .ev_props(ev_props),
    .ev_ready(m_ev_ready), .mon_reset(m_mon_reset),
    .mon_run(m_mon_run), .mon_symbols(m_mon_symbols),
    .busy(m_busy), .drop_cnt(m_drop_cnt)
  );

  ltl_symbol_encoder #(.RESET_CYCLES(10)) u_long (
    .clk(clk), .rst_n(rst_n),
    .trace_start(trace_start), .trace_end(trace_end),
    .ev_valid(ev_valid), .ev_props(ev_props),
    .ev_ready(l_ev_ready), .mon_reset(l_mon_reset),
    .mon_run(l_mon_run), .mon_symbols(l_mon_symbols),
    .busy(l_busy), .drop_cnt(l_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_trace();
    trace_start = 1'b1;
    tick();
    trace_start = 1'b0;
  endtask

  task automatic drain_m(input int budget);
    for (int k = 0; k < budget && exp_m.size() != 0; k++)
      tick();
    check("drain_m", 16'(exp_m.size()), 16'd0);
  endtask

  task automatic drain_l(input int budget);
    for (int k = 0; k < budget && exp_l.size() != 0; k++)
      tick();
    check("drain_l", 16'(exp_l.size()), 16'd0);
  endtask

  // scoreboard: every symbol strobe must match the oldest expected entry
  always @(negedge clk) begin
    logic [7:0] e;
    if (en_m && m_mon_run) begin
      n_tests++;
      assert (exp_m.size() != 0) else begin
        n_fail++;
        $error("FAIL m_unexpected observed=%h expected=none",
               m_mon_symbols);
      end
      if (exp_m.size() != 0) begin
        e = exp_m.pop_front();
        assert (m_mon_symbols === e) else begin
          n_fail++;
          $error("FAIL m_sym observed=%h expected=%h", m_mon_symbols, e);
        end
      end
    end
    if (en_l && l_mon_run) begin
      n_tests++;
      assert (exp_l.size() != 0) else begin
        n_fail++;
        $error("FAIL l_unexpected observed=%h expected=none",
               l_mon_symbols);
      end
      if (exp_l.size() != 0) begin
        e = exp_l.pop_front();
        assert (l_mon_symbols === e) else begin
          n_fail++;
          $error("FAIL l_sym observed=%h expected=%h", l_mon_symbols, e);
        end
      end
    end
  end

  initial begin
    logic [6:0] seq6 [5];
    logic [6:0] prev;
    rst_n       = 1'b0;
    trace_start = 1'b0;
    trace_end   = 1'b0;
    ev_valid    = 1'b0;
    ev_props    = '0;
    repeat (3) tick();

    // reset state
    check("rst_mon_reset", 16'(m_mon_reset), 16'd0);
    check("rst_mon_run", 16'(m_mon_run), 16'd0);
    check("rst_mon_sym", 16'(m_mon_symbols), 16'd0);
    check("rst_busy", 16'(m_busy), 16'd0);
    check("rst_ev_ready", 16'(m_ev_ready), 16'd0);
    check("rst_drop", m_drop_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // reset framing and in-order streaming, short reset
    en_m = 1;
    start_trace();
    check("t2_reset_c1", 16'(m_mon_reset), 16'd1);
    check("t2_busy", 16'(m_busy), 16'd1);
    check("t2_run_c1", 16'(m_mon_run), 16'd0);
    tick();
    check("t2_reset_c2", 16'(m_mon_reset), 16'd1);
    tick();
    check("t2_reset_off", 16'(m_mon_reset), 16'd0);
    ev_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] p;
      p = (i == 0) ? 8'h05 : (i == 1) ? 8'h21 : 8'h7F;
      ev_props = p[6:0];
      check("t2_ready", 16'(m_ev_ready), 16'd1);
      exp_m.push_back(p);
      tick();
      check("t2_run_next", 16'(m_mon_run), 16'd1);
      check("t2_sym_next", 16'(m_mon_symbols), 16'(p));
    end
    ev_valid = 1'b0;
    drain_m(10);
    en_m = 0;

    // fill the FIFO during a long reset
    en_l = 1;
    start_trace();
    ev_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ev_props = 7'(i);
      check("t3_ready", 16'(l_ev_ready), (i <= 8) ? 16'd1 : 16'd0);
      if (i <= 8)
        exp_l.push_back(8'(i));
      tick();
    end
    ev_valid = 1'b0;
    check("t3_drop", l_drop_cnt, 16'd2);
    check("t3_reset_off", 16'(l_mon_reset), 16'd0);
    drain_l(20);

    // trace_end with four queued, late events dropped
    start_trace();
    ev_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_props = 7'h31 + 7'(i);
      exp_l.push_back(8'h31 + 8'(i));
      tick();
    end
    ev_valid  = 1'b0;
    trace_end = 1'b1;
    tick();
    trace_end = 1'b0;
    ev_valid  = 1'b1;
    ev_props  = 7'h55;
    check("t4_ready_end", 16'(l_ev_ready), 16'd0);
    tick();
    tick();
    ev_valid = 1'b0;
    check("t4_drop", l_drop_cnt, 16'd2);
    exp_l.push_back(8'h80);
    drain_l(30);
    check("t4_busy", 16'(l_busy), 16'd0);
    check("t4_run", 16'(l_mon_run), 16'd0);
    check("t4_drop_hold", l_drop_cnt, 16'd2);

    // restart mid-stream flushes stale entries
    start_trace();
    ev_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ev_props = 7'h41 + 7'(i);
      tick();
    end
    ev_valid = 1'b0;
    repeat (5) tick();
    check("t5_in_stream", 16'(l_mon_reset), 16'd0);
    start_trace();
    check("t5_run", 16'(l_mon_run), 16'd0);
    for (int k = 0; k < 10; k++) begin
      check("t5_l_reset", 16'(l_mon_reset), 16'd1);
      check("t5_m_reset", 16'(m_mon_reset), (k < 2) ? 16'd1 : 16'd0);
      tick();
    end
    check("t5_l_reset_off", 16'(l_mon_reset), 16'd0);
    repeat (4) tick();
    trace_start = 1'b1;
    trace_end   = 1'b1;
    tick();
    trace_start = 1'b0;
    trace_end   = 1'b0;
    repeat (14) tick();
    check("t5_no_eot_busy", 16'(l_busy), 16'd1);

    // asynchronous reset with three entries still queued
    start_trace();
    ev_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ev_props = 7'h61 + 7'(i);
      tick();
    end
    ev_valid = 1'b0;
    repeat (5) tick();
    exp_l.push_back(8'h61);
    exp_l.push_back(8'h62);
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_mon_reset", 16'(l_mon_reset), 16'd0);
    check("t1_mon_run", 16'(l_mon_run), 16'd0);
    check("t1_mon_sym", 16'(l_mon_symbols), 16'd0);
    tick();
    check("t1_busy", 16'(l_busy), 16'd0);
    check("t1_ev_ready", 16'(l_ev_ready), 16'd0);
    check("t1_drop", l_drop_cnt, 16'd0);
    check("t1_sb_empty", 16'(exp_l.size()), 16'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t1_idle_run", 16'(l_mon_run), 16'd0);
    en_l = 0;

    // stutter removal (or plain pass-through)
    en_m = 1;
    seq6[0] = 7'h11;
    seq6[1] = 7'h11;
    seq6[2] = 7'h11;
    seq6[3] = 7'h22;
    seq6[4] = 7'h11;
    start_trace();
    tick();
    tick();
    prev = '0;
    ev_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ev_props = seq6[i];
`ifdef LTL_ENC_DEDUP_EN
      if (i == 0 || seq6[i] != prev)
        exp_m.push_back({1'b0, seq6[i]});
`else
      exp_m.push_back({1'b0, seq6[i]});
`endif
      prev = seq6[i];
      tick();
    end
    ev_valid = 1'b0;
    drain_m(10);
    check("t6_drop", m_drop_cnt, 16'd0);
    start_trace();
    tick();
    tick();
    ev_valid = 1'b1;
    ev_props = 7'h11;
    exp_m.push_back(8'h11);
    tick();
    ev_valid = 1'b0;
    drain_m(10);
    repeat (2) tick();
    en_m = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
